// File: rtl/ps2_pkg.sv
// Shared PS/2 types, parity helper and keyboard command constants.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RELEASE,
      SHIFT,
      ACK,
      WAIT_IDLE,
      DONE
   } ps2_state_e;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioner: 2-flop synchronizer plus a stability filter.
// Also usable by the keyboard receiver.
module ps2_clk_filter #(
   parameter int unsigned FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clk_i,
   output logic level_o,
   output logic fall_o
);

   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic          s1_q, s2_q;
   logic          filt_q, filt_d;
   logic          fall_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Level only flips after FILTER_LEN consecutive samples disagree with it.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == CW'(FILTER_LEN - 1)) filt_d = s2_q;
         else                              cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         filt_q <= 1'b1;
         cnt_q  <= '0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= clk_i;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
         fall_q <= filt_q & ~filt_d;
      end
   end

   assign level_o = filt_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter using the request-to-send sequence.
// Lines are open-drain: the *_oe outputs only ever pull low.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYC   = 6000,
   parameter int unsigned START_TMO_CYC = 750000,
   parameter int unsigned FRAME_TMO_CYC = 100000,
   parameter int unsigned FILTER_LEN    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       done,
   output logic       ack_ok,
   output logic       err,
   output logic       rx_inhibit,
   input  logic       ps2_clk_i,
   output logic       ps2_clk_oe,
   input  logic       ps2_data_i,
   output logic       ps2_data_oe
);

   localparam int unsigned TMO_MAX = (START_TMO_CYC > FRAME_TMO_CYC) ? START_TMO_CYC : FRAME_TMO_CYC;
   localparam int unsigned TW      = $clog2(TMO_MAX + 1);

   ps2_state_e    state_q, state_d;
   logic [TW-1:0] timer_q;
   logic [3:0]    idx_q;
   logic [7:0]    data_q;
   logic          par_q, dbit_q, ack_ok_q, err_q;
   logic          data_s1_q, data_s2_q;
   logic          clk_filt, fall;
   logic          accept, fail;
   logic          inh_last, start_tmo, frame_tmo;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_i   (ps2_clk_i),
      .level_o (clk_filt),
      .fall_o  (fall)
   );

   assign inh_last  = (timer_q == TW'(INHIBIT_CYC - 1));
   assign start_tmo = (timer_q == TW'(START_TMO_CYC - 1));
   assign frame_tmo = (timer_q == TW'(FRAME_TMO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Timeouts are checked before falls so a coincident timeout wins.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      fail    = 1'b0;
      unique case (state_q)
         IDLE:      if (tx_valid) begin accept = 1'b1; state_d = INHIBIT; end
         INHIBIT:   if (inh_last) state_d = RELEASE;
         RELEASE:   if (start_tmo) fail = 1'b1; else if (fall) state_d = SHIFT;
         SHIFT:     if (frame_tmo) fail = 1'b1; else if (fall && idx_q == 4'd9) state_d = ACK;
         ACK: begin
            if (frame_tmo)                  fail = 1'b1;
            else if (fall && data_s2_q)     fail = 1'b1;
            else if (fall)                  state_d = WAIT_IDLE;
         end
         WAIT_IDLE: if (frame_tmo) fail = 1'b1; else if (clk_filt && data_s2_q) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      if (fail) state_d = DONE;
   end

   always_comb begin
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      unique case (state_q)
         INHIBIT: begin ps2_clk_oe = 1'b1; ps2_data_oe = inh_last; end
         RELEASE: ps2_data_oe = 1'b1;
         SHIFT:   ps2_data_oe = dbit_q;
         default: ;
      endcase
   end

   // Fall 1 is taken in RELEASE and drives bit 0, so idx_q holds the next bit index
   // once in SHIFT; the frame timer starts at 1 to count that first fall cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q   <= '0;
         idx_q     <= '0;
         data_q    <= '0;
         par_q     <= 1'b0;
         dbit_q    <= 1'b0;
         ack_ok_q  <= 1'b0;
         err_q     <= 1'b0;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
      end else begin
         data_s1_q <= ps2_data_i;
         data_s2_q <= data_s1_q;
         unique case (state_q)
            IDLE: if (accept) begin
               data_q   <= tx_data;
               par_q    <= odd_parity(tx_data);
               ack_ok_q <= 1'b0;
               err_q    <= 1'b0;
               timer_q  <= '0;
            end
            INHIBIT: timer_q <= inh_last ? '0 : timer_q + 1'b1;
            RELEASE: begin
               idx_q <= '0;
               if (fall) begin
                  timer_q <= TW'(1);
                  idx_q   <= 4'd1;
                  dbit_q  <= ~data_q[0];
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            SHIFT: begin
               timer_q <= timer_q + 1'b1;
               if (fall) begin
                  idx_q <= idx_q + 1'b1;
                  if (idx_q < 4'd8)       dbit_q <= ~data_q[idx_q[2:0]];
                  else if (idx_q == 4'd8) dbit_q <= ~par_q;
                  else                    dbit_q <= 1'b0;
               end
            end
            ACK, WAIT_IDLE: timer_q <= timer_q + 1'b1;
            default: ;
         endcase
         if (fail) begin
            ack_ok_q <= 1'b0;
            err_q    <= 1'b1;
         end else if (state_q == WAIT_IDLE && state_d == DONE) begin
            ack_ok_q <= 1'b1;
            err_q    <= 1'b0;
         end
      end
   end

   assign tx_ready   = (state_q == IDLE);
   assign rx_inhibit = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign ack_ok     = ack_ok_q;
   assign err        = err_q;

endmodule
